// File: rtl/aeb_sccb_tx.sv
// SCCB 3-phase register writer: START, ID/addr/data bytes each followed by a released X cell, STOP.
// One write takes 113 SCL quarters (113*CLK_DIV clk); req_ready is high only in IDLE, and requests seen while busy are dropped.
module aeb_sccb_tx #(
    parameter int unsigned CLK_DIV = 4,
    parameter logic [7:0]  DEV_ID  = 8'h42
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic       sio_c,
    output logic       sio_d_out,
    output logic       sio_d_oe,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [7:0] QMAX = 8'(CLK_DIV - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  qcnt_q, qcnt_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [4:0]  bit_q, bit_d;
    logic [26:0] sh_q, sh_d;
    logic        done_q, done_d;

    logic accept;
    logic q_wrap;
    logic ack_cell;

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign accept    = req_valid && req_ready;
    assign q_wrap    = (qcnt_q == QMAX);
    assign ack_cell  = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26);

    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        done_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            qcnt_d = 8'd0;
            qtr_d  = 2'd0;
            bit_d  = 5'd0;
            if (accept) begin
                state_d = ST_START;
                // Whole frame is preloaded; the X cells carry 0 so the shifter never needs gaps.
                sh_d    = {DEV_ID, 1'b0, req_addr, 1'b0, req_data, 1'b0};
            end
        end else begin
            qcnt_d = q_wrap ? 8'd0 : qcnt_q + 8'd1;
        end
        if (q_wrap) begin
            case (state_q)
                ST_START: begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd1) begin
                        qtr_d   = 2'd0;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        sh_d  = {sh_q[25:0], 1'b0};
                        bit_d = bit_q + 5'd1;
                        if (bit_q == 5'd26) begin
                            bit_d   = 5'd0;
                            state_d = ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd2) begin
                        qtr_d   = 2'd0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sio_c     = 1'b1;
        sio_d_out = 1'b1;
        sio_d_oe  = 1'b1;
        case (state_q)
            ST_START: sio_d_out = (qtr_q == 2'd0);
            ST_SHIFT: begin
                sio_c     = qtr_q[1];
                sio_d_oe  = !ack_cell;
                sio_d_out = ack_cell ? 1'b0 : sh_q[26];
            end
            ST_STOP: begin
                sio_c     = (qtr_q != 2'd0);
                sio_d_out = (qtr_q == 2'd2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            qcnt_q  <= 8'd0;
            qtr_q   <= 2'd0;
            bit_q   <= 5'd0;
            sh_q    <= 27'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            done_q  <= done_d;
        end
    end

endmodule
